// File: rtl/gamepad_emu.sv
// Device-side serial gamepad responder: emulates shift-register pads that
// answer gp_latch / gp_clk / gp_sel, with button state taken from pad_value.
module gamepad_emu #(
    parameter int SEL_WIDTH   = 1,
    parameter int DATA_WIDTH  = 2,
    parameter int BITS        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [SEL_WIDTH-1:0]                      gp_sel,
    input  logic                                      gp_latch,
    input  logic                                      gp_clk,
    output logic [DATA_WIDTH-1:0]                     gp_data,
    input  logic [(2**SEL_WIDTH)*DATA_WIDTH*BITS-1:0] pad_value,
    output logic                                      pad_ack,
    output logic [$clog2(BITS+1)-1:0]                 bit_cnt
);

    localparam int NPADS = (2**SEL_WIDTH) * DATA_WIDTH;
    localparam int CW    = $clog2(BITS + 1);
    localparam int PW    = (NPADS > 1) ? $clog2(NPADS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BITS);

    logic [SYNC_STAGES-1:0]                latch_sync_q;
    logic [SYNC_STAGES-1:0]                clk_sync_q;
    logic [SYNC_STAGES-1:0][SEL_WIDTH-1:0] sel_sync_q;
    logic                                  latch_dly_q;
    logic                                  clk_dly_q;

    logic                  latch_s;
    logic                  clk_s;
    logic [SEL_WIDTH-1:0]  sel_s;
    logic                  latch_fall;
    logic                  clk_rise;

    logic [NPADS-1:0][BITS-1:0] sr_q, sr_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic                       ack_q, ack_d;
    logic [PW-1:0]              pidx;

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign sel_s      = sel_sync_q[SYNC_STAGES-1];
    assign latch_fall = latch_dly_q & ~latch_s;
    assign clk_rise   = clk_s & ~clk_dly_q;

    // Load has priority: a clk edge seen while latched never shifts.
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        ack_d  = latch_fall;
        data_d = '1;
        pidx   = '0;
        if (latch_s) begin
            for (int p = 0; p < NPADS; p++) begin
                sr_d[p] = pad_value[p*BITS +: BITS];
            end
            cnt_d = '0;
        end else if (clk_rise) begin
            for (int p = 0; p < NPADS; p++) begin
                sr_d[p] = {1'b1, sr_q[p][BITS-1:1]};
            end
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        for (int d = 0; d < DATA_WIDTH; d++) begin
            pidx      = PW'(int'(sel_s) * DATA_WIDTH + d);
            data_d[d] = ~sr_q[pidx][0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_sync_q <= '0;
            clk_sync_q   <= '1;
            sel_sync_q   <= '0;
            latch_dly_q  <= 1'b0;
            clk_dly_q    <= 1'b1;
            sr_q         <= '0;
            cnt_q        <= '0;
            data_q       <= '1;
            ack_q        <= 1'b0;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], gp_latch};
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], gp_clk};
            sel_sync_q   <= {sel_sync_q[SYNC_STAGES-2:0], gp_sel};
            latch_dly_q  <= latch_s;
            clk_dly_q    <= clk_s;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            ack_q        <= ack_d;
        end
    end

    assign gp_data = data_q;
    assign pad_ack = ack_q;
    assign bit_cnt = cnt_q;

endmodule

// File: doc/gamepad_emu.md
Name: gamepad_emu

Overview:
- Device-side responder for the serial gamepad bus: emulates up to 2^SEL_WIDTH × DATA_WIDTH shift-register pads answering the gamepad controller's gp_latch / gp_clk / gp_sel.
- Button state comes from a parallel pad_value word, typically a CSR or a bridge from a real input source.
- Used for board loopback bring-up and for self-checking simulation against the controller.
- Pins are asynchronous to clk; all sampling goes through synchronizers.

Parameters:
- SEL_WIDTH, 1: width of gp_sel; 2^SEL_WIDTH pad groups.
- DATA_WIDTH, 2: serial data lines per group.
- BITS, 16: bits per pad.
- SYNC_STAGES, 2: synchronizer depth on the gp_* inputs, >= 2.
- Derived: NPADS = (2^SEL_WIDTH)*DATA_WIDTH, pad p = sel*DATA_WIDTH + d; VW = NPADS*BITS (64 at defaults).

Ports:
- clk        in   1           system clock
- rst_n      in   1           asynchronous reset, active-low
- gp_sel     in   SEL_WIDTH   group select from controller (async)
- gp_latch   in   1           parallel load strobe, active-high (async)
- gp_clk     in   1           shift clock, idles high (async)
- gp_data    out  DATA_WIDTH  serial data, active-low on wire (0 = pressed)
- pad_value  in   VW          button state, 1 = pressed; pad p at [p*BITS +: BITS], bit 0 shifted first
- pad_ack    out  1           one-cycle pulse, pad_value captured (latch release)
- bit_cnt    out  log2(BITS+1) shifts since last latch, saturating at BITS

Behaviour:
- Synchronizers: SYNC_STAGES flops each for gp_latch, gp_clk, gp_sel.
  - Reset values: latch 0, clk 1, sel 0.
  - Edges are detected on the last stage vs. one extra delay flop: latch_fall, clk_rise.
- Per-pad shift register sr[p] (BITS wide, logical polarity, 1 = pressed).
- LOAD: while latch_s = 1, every cycle:
  - sr[p] <= pad_value slice;
  - bit_cnt <= 0.
  - The captured value is pad_value at the last cycle latch_s is high.
- pad_ack: exactly one cycle, on the cycle after latch_fall is detected. Never asserted otherwise.
- SHIFT: on clk_rise with latch_s = 0:
  - sr[p] <= {1'b1, sr[p][BITS-1:1]} for all pads;
  - bit_cnt increments, saturating at BITS.
  - After BITS shifts, every pad reads logical 1 (wire 0) until the next latch.
- clk_rise while latch_s = 1 is ignored; no shift, no count.
- Latch rise and clk_rise in the same cycle: load wins.
- Output: gp_data[d] registered <= ~sr[sel_s*DATA_WIDTH + d][0].
  - A change in sel_s changes gp_data one cycle later, no other side effect.
- Latency: any pin edge reaches gp_data in at most SYNC_STAGES+2 clk cycles.
  - The controller must hold each gp_clk / gp_latch level for at least SYNC_STAGES+2 cycles.
  - Shorter pulses may be missed; this is not an error.
- Reset (async assert, sync release via the flops), also mid-transfer:
  - sr[p] = 0; gp_data = all 1 (released);
  - bit_cnt = 0; pad_ack = 0;
  - synchronizers at their reset values.
  - The next frame starts only at the next latch.
- No other state: frames are independent, no buffering beyond sr.

Test Plan:
- Reset release, pins idle (latch 0, clk 1, sel 0) -> gp_data = 2'b11, pad_ack = 0, bit_cnt = 0 for 100 cycles.
- pad_value = 64'h0001_8000_00FF_A5A5, latch pulse 8 cycles, then 16 clk low/high pulses (6 cycles each), sel = 0:
  - gp_data[0] serializes ~16'hA5A5 LSB first; gp_data[1] serializes ~16'h00FF;
  - pad_ack pulses once; bit_cnt ends at 16.
- Same frame with sel = 1 -> gp_data[0] = ~16'h8000, gp_data[1] = ~16'h0001 bitwise; 17th–20th clocks give gp_data = 2'b00, bit_cnt stays 16.
- pad_value changes during the latch-high window, then latch falls -> value from the last latch-high cycle is shifted; clk pulses during latch are ignored (bit_cnt = 0 at release).
- Latch rise coincident with clk rise, then rst_n asserted after 5 shifts -> load wins; after reset gp_data = 2'b11, bit_cnt = 0, no pad_ack.
- Loopback with the gamepad controller (DIV 15, SEL_WIDTH 1, DATA_WIDTH 2, 25.125 MHz) -> the controller's 64-bit gp_value equals pad_value on every poll after the first.
